// File: rtl/core_bus_bridge.sv
// Bus sequencer between a single-cycle core and variable-latency instruction/data buses.
// One fetch plus an optional load/store per instruction, then a one-cycle core_step.
module core_bus_bridge #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [XLEN-1:0]  core_pc,
   output logic [XLEN-1:0]  core_inst,
   input  logic [XLEN-1:0]  core_addr,
   input  logic [XLEN-1:0]  core_wdata,
   input  logic [3:0]       core_wmask,
   input  logic             core_wen,
   input  logic             core_ren,
   output logic [XLEN-1:0]  core_rdata,
   output logic             core_step,
   output logic             ibus_valid,
   input  logic             ibus_ready,
   output logic [XLEN-1:0]  ibus_addr,
   input  logic             ibus_rvalid,
   input  logic [XLEN-1:0]  ibus_rdata,
   input  logic             ibus_err,
   output logic             dbus_valid,
   input  logic             dbus_ready,
   output logic             dbus_we,
   output logic [XLEN-1:0]  dbus_addr,
   output logic [XLEN-1:0]  dbus_wdata,
   output logic [3:0]       dbus_wmask,
   input  logic             dbus_rvalid,
   input  logic [XLEN-1:0]  dbus_rdata,
   input  logic             dbus_err,
   output logic             halted,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instret_cnt
);

   typedef enum logic [2:0] {
      IDLE, FETCH, IWAIT, EXEC, DREQ, DWAIT, COMMIT, HALT
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] inst_q, rdata_q;
   logic            mem_op;

   assign mem_op = core_wen | core_ren;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:   state_d = FETCH;
         FETCH:  if (ibus_ready) state_d = IWAIT;
         IWAIT:  if (ibus_rvalid) state_d = ibus_err ? HALT : EXEC;
         EXEC:   state_d = mem_op ? DREQ : FETCH;
         DREQ:   if (dbus_ready) state_d = DWAIT;
         DWAIT:  if (dbus_rvalid) state_d = dbus_err ? HALT : COMMIT;
         COMMIT: state_d = FETCH;
         HALT:   state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // Data request fields are captured once in EXEC so they stay frozen across ready stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inst_q     <= '0;
         rdata_q    <= '0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_wmask <= '0;
      end else begin
         if (state_q == IWAIT && ibus_rvalid) inst_q <= ibus_rdata;
         if (state_q == EXEC && mem_op) begin
            dbus_we    <= core_wen;
            dbus_addr  <= core_addr;
            dbus_wdata <= core_wdata;
            dbus_wmask <= core_wen ? core_wmask : 4'b0000;
         end
         if (state_q == DWAIT && dbus_rvalid && !dbus_we) rdata_q <= dbus_rdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (state_q != HALT) cycle_cnt   <= cycle_cnt + CNT_W'(1);
         if (core_step)       instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end

   assign core_step  = (state_q == COMMIT) || (state_q == EXEC && !mem_op);
   assign ibus_valid = (state_q == FETCH);
   assign ibus_addr  = (state_q == FETCH) ? core_pc : '0;
   assign dbus_valid = (state_q == DREQ);
   assign halted     = (state_q == HALT);
   assign core_inst  = inst_q;
   assign core_rdata = rdata_q;

endmodule

// File: tb/tb_core_bus_bridge.sv
// Random bus agents and a transaction-level model of the bridge; the bench also plays the core.
module tb_core_bus_bridge;
   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [XLEN-1:0]  core_pc = '0, core_addr = '0, core_wdata = '0;
   logic [3:0]       core_wmask = '0;
   logic             core_wen = 1'b0, core_ren = 1'b0;
   logic [XLEN-1:0]  core_inst, core_rdata, ibus_addr, dbus_addr, dbus_wdata;
   logic             core_step, ibus_valid, dbus_valid, dbus_we, halted;
   logic [3:0]       dbus_wmask;
   logic             ibus_ready = 1'b0, ibus_rvalid = 1'b0, ibus_err = 1'b0;
   logic             dbus_ready = 1'b0, dbus_rvalid = 1'b0, dbus_err = 1'b0;
   logic [XLEN-1:0]  ibus_rdata = '0, dbus_rdata = '0;
   logic [CNT_W-1:0] cycle_cnt, instret_cnt;

   core_bus_bridge #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .core_pc(core_pc), .core_inst(core_inst),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_wmask(core_wmask),
      .core_wen(core_wen), .core_ren(core_ren), .core_rdata(core_rdata), .core_step(core_step),
      .ibus_valid(ibus_valid), .ibus_ready(ibus_ready), .ibus_addr(ibus_addr),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata), .ibus_err(ibus_err),
      .dbus_valid(dbus_valid), .dbus_ready(dbus_ready), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_wmask(dbus_wmask),
      .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
      .halted(halted), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
   );

   always #5 clk = ~clk;

   // One instruction's worth of bus behaviour: stall lengths, latencies, payload, errors.
   typedef struct {
      logic [XLEN-1:0] inst, wdata, rdata;
      int              i_lo, i_lat, d_lo, d_lat;
      bit              ierr, derr;
   } txn_t;

   txn_t dq[$];
   int   n_chk = 0, n_fail = 0;

   // model state
   int               cyc;
   bit               i_want, d_want, step_want, halt_want, i_out, d_out, exec_flag, lit_en;
   int               i_lo, i_wt, d_lo, d_wt;
   logic [XLEN-1:0]  pc, gpr, cur_inst, exp_rdata;
   logic [CNT_W-1:0] exp_cyc, exp_ins;
   txn_t             cur_t;
   int               step_cyc[$];
   logic [XLEN-1:0]  step_rd[$];

   function automatic bit is_ld(logic [XLEN-1:0] i); return i[1:0] == 2'b01; endfunction
   function automatic bit is_st(logic [XLEN-1:0] i); return i[1:0] == 2'b10; endfunction

   function automatic txn_t mk(logic [XLEN-1:0] inst, wdata, rdata,
                               int il, ilat, dl, dlat, bit ie, de);
      txn_t t;
      t.inst = inst; t.wdata = wdata; t.rdata = rdata;
      t.i_lo = il; t.i_lat = ilat; t.d_lo = dl; t.d_lat = dlat; t.ierr = ie; t.derr = de;
      return t;
   endfunction

   function automatic txn_t next_txn();
      if (dq.size() != 0) return dq.pop_front();
      return mk($urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   // The core decodes its held instruction combinationally.
   task automatic drive_core();
      core_pc    = pc;
      core_ren   = is_ld(core_inst);
      core_wen   = is_st(core_inst);
      core_addr  = {core_inst[31:2], 2'b00};
      core_wmask = core_inst[7:4];
      core_wdata = gpr;
   endtask

   task automatic do_reset(int n);
      @(negedge clk);
      reset_n = 1'b0;
      {ibus_ready, ibus_rvalid, ibus_err, dbus_ready, dbus_rvalid, dbus_err} = '0;
      #1;
      chk("rst_outputs", {63'd0, |{ibus_valid, dbus_valid, core_step, halted, dbus_we}}, 64'd0);
      chk("rst_counters", 64'({cycle_cnt, instret_cnt}), 64'd0);
      chk("rst_inst_rdata", {core_inst, core_rdata}, 64'd0);
      chk("rst_addrs", {ibus_addr, dbus_addr}, 64'd0);
      repeat (n) @(negedge clk);
      reset_n = 1'b1;
      pc = 32'h8000_0000; gpr = '0; cur_inst = '0; exp_rdata = '0;
      cyc = 1; exp_cyc = CNT_W'(1); exp_ins = '0;
      i_want = 1'b1; d_want = 1'b0; step_want = 1'b0; halt_want = 1'b0;
      i_out = 1'b0; d_out = 1'b0; exec_flag = 1'b0;
      cur_t = next_txn(); i_lo = cur_t.i_lo; gpr = cur_t.wdata;
   endtask

   task automatic run_cycle();
      bit n_i, n_d, n_s, n_h;
      @(negedge clk);
      drive_core();
      #1;
      chk("ibus_valid", 64'(ibus_valid), 64'(i_want));
      chk("dbus_valid", 64'(dbus_valid), 64'(d_want));
      chk("core_step", 64'(core_step), 64'(step_want));
      chk("halted", 64'(halted), 64'(halt_want));
      chk("cycle_cnt", 64'(cycle_cnt), 64'(exp_cyc));
      chk("instret_cnt", 64'(instret_cnt), 64'(exp_ins));
      if (i_want) chk("ibus_addr", 64'(ibus_addr), 64'(pc));
      if (d_want) begin
         chk("dbus_we", 64'(dbus_we), 64'(is_st(cur_inst)));
         chk("dbus_addr", 64'(dbus_addr), 64'({cur_inst[31:2], 2'b00}));
         chk("dbus_wmask", 64'(dbus_wmask), 64'(is_st(cur_inst) ? cur_inst[7:4] : 4'b0000));
         if (is_st(cur_inst)) chk("dbus_wdata", 64'(dbus_wdata), 64'(gpr));
      end
      if (step_want) begin
         chk("core_inst", 64'(core_inst), 64'(cur_inst));
         if (is_ld(cur_inst)) chk("core_rdata", 64'(core_rdata), 64'(exp_rdata));
         step_cyc.push_back(cyc);
         step_rd.push_back(core_rdata);
      end
      if (cyc == 64 && !halt_want) chk("cycle_wrap", 64'(cycle_cnt), 64'd0);
      if (lit_en && cyc == 4) chk("lit_instret_1", 64'(instret_cnt), 64'd1);

      n_i = 1'b0; n_d = 1'b0; n_s = 1'b0; n_h = halt_want;
      ibus_rvalid = 1'b0; ibus_err = 1'b0; ibus_rdata = $urandom;
      dbus_rvalid = 1'b0; dbus_err = 1'b0; dbus_rdata = $urandom;
      ibus_ready = 1'($urandom_range(0, 1));
      dbus_ready = 1'($urandom_range(0, 1));
      // Outside an outstanding transaction rvalid/err may glitch; the bridge must ignore it.
      if (!i_out && !i_want && $urandom_range(0, 3) == 0) begin
         ibus_rvalid = 1'b1; ibus_err = 1'($urandom_range(0, 1));
      end
      if (!d_out && !d_want && $urandom_range(0, 3) == 0) begin
         dbus_rvalid = 1'b1; dbus_err = 1'($urandom_range(0, 1));
      end
      if (!halt_want) begin
         if (exec_flag) begin
            exec_flag = 1'b0; n_d = 1'b1; d_lo = cur_t.d_lo;
         end
         if (i_out) begin
            if (i_wt == 0) begin
               ibus_rvalid = 1'b1; ibus_rdata = cur_t.inst; ibus_err = cur_t.ierr; i_out = 1'b0;
               if (cur_t.ierr) n_h = 1'b1;
               else begin
                  cur_inst = cur_t.inst;
                  if (is_ld(cur_inst) || is_st(cur_inst)) exec_flag = 1'b1;
                  else n_s = 1'b1;
               end
            end else i_wt--;
         end
         if (i_want) begin
            if (i_lo == 0) begin ibus_ready = 1'b1; i_out = 1'b1; i_wt = cur_t.i_lat; end
            else begin ibus_ready = 1'b0; i_lo--; n_i = 1'b1; end
         end
         if (d_out) begin
            if (d_wt == 0) begin
               dbus_rvalid = 1'b1; dbus_rdata = cur_t.rdata; dbus_err = cur_t.derr; d_out = 1'b0;
               if (cur_t.derr) n_h = 1'b1;
               else begin
                  n_s = 1'b1;
                  if (is_ld(cur_inst)) exp_rdata = cur_t.rdata;
               end
            end else d_wt--;
         end
         if (d_want) begin
            if (d_lo == 0) begin dbus_ready = 1'b1; d_out = 1'b1; d_wt = cur_t.d_lat; end
            else begin dbus_ready = 1'b0; d_lo--; n_d = 1'b1; end
         end
         if (step_want) begin
            n_i = 1'b1; exp_ins = exp_ins + 1'b1; pc = pc + 32'd4;
            cur_t = next_txn(); i_lo = cur_t.i_lo; gpr = cur_t.wdata;
         end
         exp_cyc = exp_cyc + 1'b1;
      end
      i_want = n_i; d_want = n_d; step_want = n_s; halt_want = n_h;
      cyc++;
   endtask

   initial begin
      // addi zero-wait, addi with 4 ready-low cycles, load with 3 wait cycles, store stalled 2
      dq.push_back(mk(32'h0000_0013, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0, 1'b0));
      dq.push_back(mk(32'h0010_0093, 32'h0, 32'h0, 4, 0, 0, 0, 1'b0, 1'b0));
      dq.push_back(mk(32'h8000_1001, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 3, 1'b0, 1'b0));
      dq.push_back(mk(32'h8000_2032, 32'h1234_5678, 32'h0, 0, 0, 2, 0, 1'b0, 1'b0));
      lit_en = 1'b1;
      do_reset(3);
      repeat (30) run_cycle();
      lit_en = 1'b0;
      if (step_cyc.size() >= 4) begin
         chk("lit_step0_cycle", 64'(step_cyc[0]), 64'd3);
         chk("lit_step1_cycle", 64'(step_cyc[1]), 64'd10);
         chk("lit_step2_cycle", 64'(step_cyc[2]), 64'd19);
         chk("lit_load_rdata", 64'(step_rd[2]), 64'hDEAD_BEEF);
         chk("lit_step3_cycle", 64'(step_cyc[3]), 64'd27);
      end else chk("lit_step_count", 64'(step_cyc.size()), 64'd4);

      repeat (600) run_cycle();

      dq.push_back(mk(32'h8000_3001, 32'h0, 32'h0, 0, 0, 0, 1, 1'b0, 1'b1));
      repeat (80) run_cycle();
      chk("lit_derr_halted", 64'(halted), 64'd1);
      chk("lit_derr_no_step", 64'(core_step), 64'd0);

      do_reset(2);
      repeat (150) run_cycle();
      dq.push_back(mk(32'h0000_0013, 32'h0, 32'h0, 1, 2, 0, 0, 1'b1, 1'b0));
      do_reset(1);
      repeat (20) run_cycle();
      chk("lit_ierr_halted", 64'(halted), 64'd1);
      chk("lit_ierr_instret", 64'(instret_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
